wb_dffram_ctrl: RTL and testbench

Wishbone classic (B4, non-pipelined) slave that fronts the single-port DFFRAM word memory and drives its CLK-synchronous EN/WE/A/Di port. It accepts one bus request at a time, issues exactly one RAM access per request, and returns ack one cycle after accept for both reads and writes, with read data taken from the RAM's registered Do. It sits directly upstream of the RAM, between the CPU/interconnect data bus and the memory macro.

---
 rtl/wb_dffram_ctrl.sv | 147 ++++++++++++++
 tb/tb_wb_dffram_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dffram_ctrl.sv
// ---------------------------------------------------------------------------
// wb_dffram_ctrl
//
// Wishbone classic (B4, non-pipelined) slave in front of a single-port
// DFFRAM word memory. The controller takes one bus request at a time and
// issues exactly one RAM access for it. It returns ack in the cycle after
// the request is accepted, for reads and for writes. Read data comes from
// the RAM's registered Do.
//
// Optional feature: define WB_DFFRAM_RANGE_CHK_EN to enable the address
// range decode. A request whose upper address bits do not match BASE_ADDR
// is then accepted without a RAM access and terminated with wb_err_o.
// When the macro is not defined, the RAM aliases across the whole address
// space and wb_err_o stays 0.
//
// Parameters:
//   ADDR_W     RAM word-address width (depth = 2**ADDR_W 32-bit words)
//   BASE_ADDR  byte base address of the RAM window (range check only)
//
// Ports:
//   CLK        system clock, shared with the RAM
//   RST        asynchronous, active-high reset
//   wb_cyc_i   bus cycle valid
//   wb_stb_i   strobe
//   wb_we_i    1 = write, 0 = read
//   wb_sel_i   byte lane selects
//   wb_adr_i   byte address (bits [1:0] ignored)
//   wb_dat_i   write data
//   wb_dat_o   read data
//   wb_ack_o   request complete
//   wb_err_o   error termination
//   ram_en     RAM EN
//   ram_we     RAM byte write enables
//   ram_a      RAM word address
//   ram_di     RAM write data
//   ram_do     RAM registered read data
// ---------------------------------------------------------------------------
module wb_dffram_ctrl #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_a,
    output logic [31:0]       ram_di,
    input  logic [31:0]       ram_do
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t      state;
    logic        ack_q;
    logic        err_q;
    logic        resp_read;
    logic [31:0] rd_q;
    logic        req;
    logic        accept;
    logic        in_range;

    assign req = wb_cyc_i & wb_stb_i;

    // Range decode: only the bits above the word index take part in the
    // comparison. Without the feature, every address is in range, so the
    // RAM aliases across the whole address space.
`ifdef WB_DFFRAM_RANGE_CHK_EN
    assign in_range = (wb_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);

    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[1:0], BASE_ADDR[ADDR_W+1:0]};
`else
    assign in_range = 1'b1;

    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[31:ADDR_W+2], wb_adr_i[1:0], BASE_ADDR};
`endif

    // A request is accepted only in IDLE. The RAM control is combinational
    // from the bus so that the RAM samples it on the same edge that moves
    // the FSM to RESP. RST gates the control so the RAM sees nothing while
    // reset is held.
    assign accept = ~RST & req & (state == IDLE);
    assign ram_en = accept & in_range;
    assign ram_we = (ram_en & wb_we_i) ? wb_sel_i : 4'b0000;
    assign ram_a  = wb_adr_i[ADDR_W+1:2];
    assign ram_di = wb_dat_i;

    // Two-state handshake FSM. ack/err are registered and last exactly one
    // cycle (the RESP cycle). The read-data register loads the RAM output on
    // the RESP->IDLE edge, and only when the completed request was a read,
    // so that it holds the last read value across writes and errors.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            resp_read <= 1'b0;
            rd_q      <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state     <= RESP;
                        ack_q     <= in_range;
                        err_q     <= ~in_range;
                        resp_read <= ~wb_we_i & in_range;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    ack_q     <= 1'b0;
                    err_q     <= 1'b0;
                    resp_read <= 1'b0;
                    if (resp_read) begin
                        rd_q <= ram_do;
                    end
                end
                default: begin
                    state <= IDLE;
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                end
            endcase
        end
    end

    // In the ack cycle of a read, the RAM output is passed straight through
    // so the data is valid together with ack. Otherwise the held copy is
    // driven.
    assign wb_dat_o = ((state == RESP) && resp_read) ? ram_do : rd_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;

endmodule

// File: tb/tb_wb_dffram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wb_dffram_ctrl
//
// Self-checking bench for wb_dffram_ctrl. A behavioural DFFRAM stands in for
// the memory macro. A word-level reference memory, updated per bus
// transaction, predicts read data. Directed cases cover reset, full and
// byte writes, held requests, reset in the ack cycle and address aliasing
// or range errors. A randomized run then issues mixed reads and writes.
// ---------------------------------------------------------------------------
module tb_wb_dffram_ctrl;

    localparam int          AW       = 8;
    localparam int          DEPTH    = 1 << AW;
    localparam logic [31:0] WIN_BASE = 32'h1000_0000;

    logic          CLK;
    logic          RST;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic          wb_we_i;
    logic [3:0]    wb_sel_i;
    logic [31:0]   wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_a;
    logic [31:0]   ram_di;
    logic [31:0]   ram_do;

    int assertCount = 0;
    int failCount   = 0;
    int enCount     = 0;

    logic [31:0] memEnv [DEPTH];
    logic [31:0] refMem [DEPTH];
    logic [31:0] lastRead;
    logic [31:0] rdata;

    wb_dffram_ctrl #(
        .ADDR_W    (AW),
        .BASE_ADDR (WIN_BASE)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_sel_i (wb_sel_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_a    (ram_a),
        .ram_di   (ram_di),
        .ram_do   (ram_do)
    );

    // 10 ns clock period.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural DFFRAM: a read-first single port with byte writes and a
    // registered Do.
    always @(posedge CLK) begin
        if (ram_en) begin
            ram_do <= memEnv[ram_a];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) memEnv[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
            end
        end
    end

    // Counts cycles in which the RAM is enabled, once per cycle.
    always @(negedge CLK) begin
        if (ram_en) enCount++;
    end

    // Compares an observed value with the expected one and counts the result.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Merges the selected byte lanes of a write into a stored word.
    function automatic logic [31:0] mergeBytes(input logic [31:0] old,
                                               input logic [31:0] dat,
                                               input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
        end
        return r;
    endfunction

    // Runs one in-range transaction. The request is driven right after a
    // clock edge. The accept cycle and the ack cycle are checked at the
    // falling edge. With hold set, the request stays asserted through the
    // ack cycle. The call returns in the ack cycle.
    task automatic applyStimulus(input logic we, input logic [3:0] sel,
                                 input logic [31:0] adr, input logic [31:0] dat,
                                 input logic hold, output logic [31:0] rd);
        int idx;
        idx = int'(adr[AW+1:2]);
        @(posedge CLK);
        #1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_sel_i = sel;
        wb_adr_i = adr;
        wb_dat_i = dat;
        @(negedge CLK);
        checkOutput("acc_en",  32'(ram_en), 32'd1);
        checkOutput("acc_we",  32'(ram_we), we ? 32'(sel) : 32'd0);
        checkOutput("acc_a",   32'(ram_a), 32'(idx));
        checkOutput("acc_di",  ram_di, dat);
        checkOutput("acc_ack", 32'(wb_ack_o), 32'd0);
        @(posedge CLK);
        #1;
        if (!hold) begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
        end
        @(negedge CLK);
        checkOutput("resp_ack", 32'(wb_ack_o), 32'd1);
        checkOutput("resp_err", 32'(wb_err_o), 32'd0);
        checkOutput("resp_en",  32'(ram_en), 32'd0);
        rd = wb_dat_o;
        if (we) begin
            refMem[idx] = mergeBytes(refMem[idx], dat, sel);
        end else begin
            checkOutput("resp_dat", wb_dat_o, refMem[idx]);
            lastRead = refMem[idx];
        end
    endtask

    // One idle cycle: no request, no RAM access, and the read register
    // holds the last read value.
    task automatic idleCycle();
        @(posedge CLK);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(negedge CLK);
        checkOutput("idle_ack",  32'(wb_ack_o), 32'd0);
        checkOutput("idle_en",   32'(ram_en), 32'd0);
        checkOutput("idle_hold", wb_dat_o, lastRead);
    endtask

`ifdef WB_DFFRAM_RANGE_CHK_EN
    // Out-of-range request: accepted without a RAM access, err instead of
    // ack, and the read register is not touched.
    task automatic outOfRange(input logic [31:0] adr);
        @(posedge CLK);
        #1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_sel_i = 4'hF;
        wb_adr_i = adr;
        @(negedge CLK);
        checkOutput("oor_en", 32'(ram_en), 32'd0);
        @(posedge CLK);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(negedge CLK);
        checkOutput("oor_err", 32'(wb_err_o), 32'd1);
        checkOutput("oor_ack", 32'(wb_ack_o), 32'd0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        checkOutput("oor_dat", wb_dat_o, lastRead);
    endtask
`endif

    initial begin
        int idx;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;

        for (int i = 0; i < DEPTH; i++) begin
            memEnv[i] = 32'h0;
            refMem[i] = 32'h0;
        end
        lastRead = 32'h0;
        ram_do   = 32'h0;

        // Reset held with a pending request: nothing reaches the RAM.
        RST      = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_sel_i = 4'hF;
        wb_adr_i = WIN_BASE + 32'h20;
        wb_dat_i = 32'hCAFE_0001;
        repeat (2) @(negedge CLK);
        checkOutput("rst_en",  32'(ram_en), 32'd0);
        checkOutput("rst_we",  32'(ram_we), 32'd0);
        checkOutput("rst_ack", 32'(wb_ack_o), 32'd0);
        checkOutput("rst_err", 32'(wb_err_o), 32'd0);
        checkOutput("rst_dat", wb_dat_o, 32'h0);

        // Release: the request is accepted on the first IDLE cycle.
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("rel_en", 32'(ram_en), 32'd1);
        checkOutput("rel_a",  32'(ram_a), 32'd8);
        @(posedge CLK);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(negedge CLK);
        checkOutput("rel_ack", 32'(wb_ack_o), 32'd1);
        refMem[8] = 32'hCAFE_0001;

        // Full write and read back at word 4.
        applyStimulus(1'b1, 4'hF, WIN_BASE + 32'h10, 32'hDEAD_BEEF, 1'b0, rdata);
        applyStimulus(1'b0, 4'hF, WIN_BASE + 32'h10, 32'h0, 1'b0, rdata);
        checkOutput("full_rd", rdata, 32'hDEAD_BEEF);
        idleCycle();

        // Byte lane write over a known word.
        applyStimulus(1'b1, 4'hF, WIN_BASE + 32'h14, 32'h1122_3344, 1'b0, rdata);
        applyStimulus(1'b1, 4'b0010, WIN_BASE + 32'h14, 32'h0000_5A00, 1'b0, rdata);
        applyStimulus(1'b0, 4'hF, WIN_BASE + 32'h14, 32'h0, 1'b0, rdata);
        checkOutput("byte_rd", rdata, 32'h1122_5A44);

        // Write with no lanes selected: acked, memory unchanged.
        applyStimulus(1'b1, 4'b0000, WIN_BASE + 32'h14, 32'hFFFF_FFFF, 1'b0, rdata);
        applyStimulus(1'b0, 4'hF, WIN_BASE + 32'h14, 32'h0, 1'b0, rdata);
        checkOutput("sel0_rd", rdata, 32'h1122_5A44);
        idleCycle();

        // Request held across three transactions: one RAM enable each.
        enCount = 0;
        applyStimulus(1'b1, 4'hF, WIN_BASE + 32'h30, 32'hA5A5_0001, 1'b1, rdata);
        applyStimulus(1'b1, 4'hF, WIN_BASE + 32'h34, 32'hA5A5_0002, 1'b1, rdata);
        applyStimulus(1'b0, 4'hF, WIN_BASE + 32'h30, 32'h0, 1'b1, rdata);
        checkOutput("held_rd", rdata, 32'hA5A5_0001);
        @(posedge CLK);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(negedge CLK);
        checkOutput("held_ack_end", 32'(wb_ack_o), 32'd0);
        checkOutput("held_en_cnt", 32'(enCount), 32'd3);

        // Reset in the ack cycle of a read.
        @(posedge CLK);
        #1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = WIN_BASE + 32'h34;
        @(posedge CLK);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        checkOutput("mid_ack_pre", 32'(wb_ack_o), 32'd1);
        RST = 1'b1;
        #1;
        checkOutput("mid_ack_rst", 32'(wb_ack_o), 32'd0);
        checkOutput("mid_dat_rst", wb_dat_o, 32'h0);
        lastRead = 32'h0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        applyStimulus(1'b0, 4'hF, WIN_BASE + 32'h34, 32'h0, 1'b0, rdata);
        checkOutput("mid_rd_after", rdata, 32'hA5A5_0002);

`ifdef WB_DFFRAM_RANGE_CHK_EN
        // Last word of the window is in range; the next word is not.
        applyStimulus(1'b1, 4'hF, WIN_BASE + 32'h3FC, 32'h7777_8888, 1'b0, rdata);
        applyStimulus(1'b0, 4'hF, WIN_BASE + 32'h3FC, 32'h0, 1'b0, rdata);
        checkOutput("win_top_rd", rdata, 32'h7777_8888);
        outOfRange(WIN_BASE + 32'h400);
`else
        // Without the range decode, 0x1000_0400 aliases to word 0.
        applyStimulus(1'b1, 4'hF, 32'h1000_0400, 32'h0BAD_F00D, 1'b0, rdata);
        applyStimulus(1'b0, 4'hF, 32'h0000_0000, 32'h0, 1'b0, rdata);
        checkOutput("alias_rd", rdata, 32'h0BAD_F00D);
`endif

        // Randomized mixed traffic over a small set of words, so that reads
        // often hit words that were written earlier.
        for (int n = 0; n < 60; n++) begin
            idx = int'($urandom_range(0, 15));
            we  = 1'($urandom_range(0, 1));
            sel = 4'($urandom);
            dat = $urandom;
`ifdef WB_DFFRAM_RANGE_CHK_EN
            adr = WIN_BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
`else
            adr = {$urandom} & ~32'h0000_03FF;
            adr = adr | 32'(idx * 4) | 32'($urandom_range(0, 3));
`endif
            applyStimulus(we, sel, adr, dat, 1'($urandom_range(0, 1)), rdata);
            if ($urandom_range(0, 3) == 0) idleCycle();
            else begin
                @(posedge CLK);
                #1;
                wb_cyc_i = 1'b0;
                wb_stb_i = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
